// File: rtl/mem_store_unit.sv
// mem_store_unit: store-side data-memory write sequencer.
// Takes a store (bot/top byte halves with per-half enables) from the EX/MEM
// register. It issues one or two byte writes over a req/ack port: bot goes to
// addr and top goes to addr+1. The pipeline is stalled until the last write
// is accepted.
// Ports:
//   clock, reset_n                      clock / async active-low reset
//   st_valid, st_en[1:0]                store request, [1]=bot half, [0]=top half
//   st_addr, st_data_top, st_data_bot   store address and data halves
//   mem_req, mem_addr, mem_wdata        registered write port to data memory
//   mem_ack                             memory accepts when mem_req & mem_ack
//   stall                               combinational pipeline freeze
//   st_done                             registered one-cycle completion pulse
module mem_store_unit #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  st_valid,
  input  logic [1:0]            st_en,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data_top,
  input  logic [DATA_WIDTH-1:0] st_data_bot,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  output logic                  stall,
  output logic                  st_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_BOT = 2'd1,
    WR_TOP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data_top;
  logic                  r_top_pend;

  logic                  w_capture;
  logic                  w_req_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic                  w_done_nxt;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus next values of the registered write-port outputs
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_req_nxt   = mem_req;
    w_addr_nxt  = mem_addr;
    w_wdata_nxt = mem_wdata;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_nxt = 1'b0;
        if (st_valid && (st_en != 2'b00)) begin
          w_capture = 1'b1;
          w_req_nxt = 1'b1;
          if (st_en[1]) begin
            w_state_nxt = WR_BOT;
            w_addr_nxt  = st_addr;
            w_wdata_nxt = st_data_bot;
          end else begin
            w_state_nxt = WR_TOP;
            w_addr_nxt  = st_addr + ADDR_WIDTH'(1);
            w_wdata_nxt = st_data_top;
          end
        end
      end
      WR_BOT: begin
        if (mem_ack) begin
          if (r_top_pend) begin
            // req stays high; only address/data move on to the top half
            w_state_nxt = WR_TOP;
            w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
            w_wdata_nxt = r_data_top;
          end else begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      WR_TOP: begin
        if (mem_ack) begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // Registered write port and completion pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      st_done   <= 1'b0;
    end else begin
      mem_req   <= w_req_nxt;
      mem_addr  <= w_addr_nxt;
      mem_wdata <= w_wdata_nxt;
      st_done   <= w_done_nxt;
    end
  end

  // Captured store, needed for the top half after the bot write is accepted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_data_top <= '0;
      r_top_pend <= 1'b0;
    end else if (w_capture) begin
      r_addr     <= st_addr;
      r_data_top <= st_data_top;
      r_top_pend <= st_en[0];
    end
  end

  // Freeze in the capture cycle and for as long as a write is outstanding
  assign stall = ((r_state == IDLE) && st_valid && (st_en != 2'b00)) ||
                 (r_state != IDLE);

endmodule

// File: tb/tb_mem_store_unit.sv
module tb_mem_store_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic          clock;
  logic          reset_n;
  logic          st_valid;
  logic [1:0]    st_en;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data_top;
  logic [DW-1:0] st_data_bot;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic          stall;
  logic          st_done;

  mem_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .st_valid    (st_valid),
    .st_en       (st_en),
    .st_addr     (st_addr),
    .st_data_top (st_data_top),
    .st_data_bot (st_data_bot),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .stall       (stall),
    .st_done     (st_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int   n_total = 0;
  int   n_bad   = 0;
  wr_t  pend_q[$];   // model: byte writes still owed to memory, in order
  logic exp_done;    // model: st_done expected this cycle
  wr_t  wr_log[$];   // writes the DUT actually got accepted

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input logic v, input logic [1:0] en, input logic [AW-1:0] a,
                      input logic [DW-1:0] top, input logic [DW-1:0] bot, input logic ack);
    logic [AW-1:0] a1;
    @(negedge clock);
    st_valid = v; st_en = en; st_addr = a; st_data_top = top; st_data_bot = bot; mem_ack = ack;
    #1;
    check_eq("stall", stall, (pend_q.size() != 0) || (v && en != 2'b00));
    check_eq("mem_req", mem_req, pend_q.size() != 0);
    if (pend_q.size() != 0) begin
      check_eq("mem_addr", mem_addr, pend_q[0].a);
      check_eq("mem_wdata", mem_wdata, pend_q[0].d);
    end
    check_eq("st_done", st_done, exp_done);
    if (mem_req && ack) wr_log.push_back({mem_addr, mem_wdata});
    exp_done = 1'b0;
    if (pend_q.size() != 0) begin
      if (ack) begin
        void'(pend_q.pop_front());
        if (pend_q.size() == 0) exp_done = 1'b1;
      end
    end else if (v && en != 2'b00) begin
      a1 = a + 16'd1;
      if (en[1]) pend_q.push_back({a, bot});
      if (en[0]) pend_q.push_back({a1, top});
    end
  endtask

  task automatic idle_steps(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, '0, ack);
  endtask

  // Cycles from the capture step (cycle 0) to the st_done pulse, bounded
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 2'b00, '0, '0, '0, 1'b1);
      if (st_done === 1'b1 && lat < 0) lat = i;
    end
  endtask

  task automatic check_log(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (idx < wr_log.size()) begin
      check_eq("log_addr", wr_log[idx].a, a);
      check_eq("log_data", wr_log[idx].d, d);
    end
  endtask

  initial begin
    int lat;
    int k;
    reset_n = 1'b0;
    st_valid = 1'b0; st_en = '0; st_addr = '0; st_data_top = '0; st_data_bot = '0; mem_ack = 1'b0;
    exp_done = 1'b0;
    #2;
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_done", st_done, 0);
    check_eq("rst_stall", stall, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single bot half, ack tied high
    wr_log.delete();
    step(1'b1, 2'b10, 16'h0040, 8'h00, 8'hA5, 1'b1);
    wait_done(lat);
    check_eq("lat_one_half", lat, 2);
    check_eq("t1_nwr", wr_log.size(), 1);
    check_log(0, 16'h0040, 8'hA5);

    // Two halves, ack delayed 3 cycles for each half
    wr_log.delete();
    step(1'b1, 2'b11, 16'h1234, 8'h3C, 8'hC3, 1'b0);
    idle_steps(3, 1'b0);
    idle_steps(1, 1'b1);
    idle_steps(3, 1'b0);
    idle_steps(1, 1'b1);
    idle_steps(2, 1'b0);
    check_eq("t2_nwr", wr_log.size(), 2);
    check_log(0, 16'h1234, 8'hC3);
    check_log(1, 16'h1235, 8'h3C);

    // Address wrap on the top half
    wr_log.delete();
    step(1'b1, 2'b11, 16'hFFFF, 8'h11, 8'h22, 1'b1);
    wait_done(lat);
    check_eq("lat_two_half", lat, 3);
    check_eq("t3_nwr", wr_log.size(), 2);
    check_log(0, 16'hFFFF, 8'h22);
    check_log(1, 16'h0000, 8'h11);

    // Top half only
    wr_log.delete();
    step(1'b1, 2'b01, 16'h0010, 8'h7E, 8'h99, 1'b1);
    wait_done(lat);
    check_eq("lat_top_only", lat, 2);
    check_eq("t4_nwr", wr_log.size(), 1);
    check_log(0, 16'h0011, 8'h7E);

    // Valid with no enables is a no-op
    wr_log.delete();
    step(1'b1, 2'b00, 16'h0300, 8'h01, 8'h02, 1'b1);
    step(1'b1, 2'b00, 16'h0300, 8'h01, 8'h02, 1'b1);
    idle_steps(2, 1'b1);
    check_eq("t5_nwr", wr_log.size(), 0);

    // Reset while waiting in the top-half write
    step(1'b1, 2'b11, 16'h0500, 8'h55, 8'hAA, 1'b0);
    idle_steps(1, 1'b1);
    idle_steps(1, 1'b0);
    @(negedge clock);
    st_valid = 1'b0; st_en = '0; mem_ack = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_req", mem_req, 0);
    check_eq("mid_rst_stall", stall, 0);
    check_eq("mid_rst_done", st_done, 0);
    pend_q.delete();
    exp_done = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    wr_log.delete();
    step(1'b1, 2'b11, 16'h0600, 8'h66, 8'h77, 1'b1);
    wait_done(lat);
    check_eq("post_rst_lat", lat, 3);
    check_eq("t6_nwr", wr_log.size(), 2);
    check_log(0, 16'h0600, 8'h77);
    check_log(1, 16'h0601, 8'h66);

    // Back-to-back: new store offered in the st_done cycle
    wr_log.delete();
    step(1'b1, 2'b10, 16'h0700, 8'h00, 8'h01, 1'b1);
    step(1'b0, 2'b00, 16'h0000, 8'h00, 8'h00, 1'b1);
    step(1'b1, 2'b01, 16'h0800, 8'h02, 8'h00, 1'b1);
    check_eq("b2b_done", st_done, 1);
    idle_steps(3, 1'b1);
    check_eq("t7_nwr", wr_log.size(), 2);
    check_log(0, 16'h0700, 8'h01);
    check_log(1, 16'h0801, 8'h02);

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 7);
      step(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
           (k == 0) ? 16'hFFFF : 16'($urandom),
           8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    idle_steps(10, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
